// File: rtl/reflet_wakeup_timer.sv
// Wakeup timer: 6-byte register window on the system bus, a 16-bit down counter
// clocked by an 8-bit prescaler, and a level interrupt that keeps working while
// the CPU clock domain is gated.
module reflet_wakeup_timer #(
  parameter int unsigned                base_addr_size = 16,
  parameter logic [base_addr_size-1:0]  base_addr      = 16'hFF20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  output logic                      wake_irq
);

  typedef enum logic {StIdle = 1'b0, StCounting = 1'b1} state_e;

  localparam logic [2:0] OffCtrl     = 3'd0;
  localparam logic [2:0] OffPrescale = 3'd1;
  localparam logic [2:0] OffReloadL  = 3'd2;
  localparam logic [2:0] OffReloadH  = 3'd3;
  localparam logic [2:0] OffCountL   = 3'd4;
  localparam logic [2:0] OffCountH   = 3'd5;

  state_e      state_q, state_d;
  logic        periodic_q, periodic_d;
  logic        irq_en_q, irq_en_d;
  logic        expired_q, expired_d;
  logic [7:0]  prescale_q, prescale_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  // Prescale limit in force for the current period; refreshed only at a wrap.
  logic [7:0]  pre_lim_q, pre_lim_d;
  logic [7:0]  shadow_q, shadow_d;

  logic [base_addr_size-1:0] offset;
  logic [2:0]                off;
  logic                      selected;
  logic                      bus_rd;
  logic                      bus_wr;
  logic                      tick;
  logic                      unused_ctrl_bits;

  // Address decode; offset is checked after subtraction so base_addr+6 cannot overflow.
  assign offset   = addr - base_addr;
  assign off      = offset[2:0];
  assign selected = enable && (addr >= base_addr) && (offset < base_addr_size'(6));
  assign bus_rd   = selected && !write_en;
  assign bus_wr   = selected && write_en;
  assign tick     = (state_q == StCounting) && (pre_cnt_q == pre_lim_q);

  assign unused_ctrl_bits = ^data_in[6:3];

  // Interrupt comes straight from registered flags only.
  assign wake_irq = expired_q & irq_en_q;

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      expired_q  <= 1'b0;
      prescale_q <= 8'h00;
      reload_q   <= 16'h0000;
      count_q    <= 16'h0000;
      pre_cnt_q  <= 8'h00;
      pre_lim_q  <= 8'h00;
      shadow_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      periodic_q <= periodic_d;
      irq_en_q   <= irq_en_d;
      expired_q  <= expired_d;
      prescale_q <= prescale_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      pre_cnt_q  <= pre_cnt_d;
      pre_lim_q  <= pre_lim_d;
      shadow_q   <= shadow_d;
    end
  end

  // Next state: bus writes first, then timer events, which win on conflicts.
  always_comb begin
    state_d    = state_q;
    periodic_d = periodic_q;
    irq_en_d   = irq_en_q;
    expired_d  = expired_q;
    prescale_d = prescale_q;
    reload_d   = reload_q;
    count_d    = count_q;
    pre_cnt_d  = pre_cnt_q;
    pre_lim_d  = pre_lim_q;
    shadow_d   = shadow_q;

    if (bus_wr) begin
      case (off)
        OffCtrl: begin
          periodic_d = data_in[1];
          irq_en_d   = data_in[2];
          if (!data_in[7]) begin
            expired_d = 1'b0;
          end
          if (data_in[0]) begin
            state_d = StCounting;
            // Only an idle->run transition restarts the count.
            if (state_q == StIdle) begin
              count_d   = reload_q;
              pre_cnt_d = 8'h00;
              pre_lim_d = prescale_q;
            end
          end else begin
            state_d = StIdle;
          end
        end
        OffPrescale: prescale_d = data_in;
        OffReloadL:  reload_d[7:0]  = data_in;
        OffReloadH:  reload_d[15:8] = data_in;
        default: ;
      endcase
    end

    if (state_q == StCounting) begin
      if (tick) begin
        pre_cnt_d = 8'h00;
        pre_lim_d = prescale_q;
        if (count_q != 16'h0000) begin
          count_d = count_q - 16'h0001;
        end else begin
          // Expiry sets the flag even against a same-cycle clear.
          expired_d = 1'b1;
          if (periodic_q) begin
            count_d = reload_q;
          end else begin
            state_d = StIdle;
          end
        end
      end else begin
        pre_cnt_d = pre_cnt_q + 8'h01;
      end
    end

    // Reading the low byte snapshots the high byte for a coherent 16-bit read.
    if (bus_rd && (off == OffCountL)) begin
      shadow_d = count_q[15:8];
    end
  end

  // Read mux; zero unless a selected read.
  always_comb begin
    data_out = 8'h00;
    if (bus_rd) begin
      case (off)
        OffCtrl:     data_out = {expired_q, 4'b0000, irq_en_q, periodic_q, state_q == StCounting};
        OffPrescale: data_out = prescale_q;
        OffReloadL:  data_out = reload_q[7:0];
        OffReloadH:  data_out = reload_q[15:8];
        OffCountL:   data_out = count_q[7:0];
        OffCountH:   data_out = shadow_q;
        default:     data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_wakeup_timer.sv
// Self-checking bench for reflet_wakeup_timer: register table, hand-written timing
// sequences, then randomized bus traffic against a behavioural model.
module tb_reflet_wakeup_timer;

  localparam logic [15:0] BASE = 16'hFF20;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] addr;
  logic        write_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        wake_irq;

  int tests = 0;
  int fails = 0;
  int cur_dout;
  int cur_irq;

  reflet_wakeup_timer #(
    .base_addr_size(16),
    .base_addr     (16'hFF20)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .addr    (addr),
    .write_en(write_en),
    .data_in (data_in),
    .data_out(data_out),
    .wake_irq(wake_irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain integers, m_wait = edges left before the next tick.
  bit m_run, m_per, m_irqen, m_exp;
  int m_pres, m_reload, m_count, m_wait, m_shadow;

  function automatic void model_reset();
    m_run = 0; m_per = 0; m_irqen = 0; m_exp = 0;
    m_pres = 0; m_reload = 0; m_count = 0; m_wait = 0; m_shadow = 0;
  endfunction

  function automatic int model_dout(bit en, logic [15:0] a, bit we);
    int off;
    off = int'(a) - int'(BASE);
    if (!en || we || off < 0 || off > 5) return 0;
    case (off)
      0:       return (int'(m_exp) << 7) | (int'(m_irqen) << 2) | (int'(m_per) << 1) | int'(m_run);
      1:       return m_pres;
      2:       return m_reload % 256;
      3:       return m_reload / 256;
      4:       return m_count % 256;
      default: return m_shadow;
    endcase
  endfunction

  function automatic bit model_expiring();
    return m_run && (m_wait == 0) && (m_count == 0);
  endfunction

  function automatic void model_step(bit en, logic [15:0] a, bit we, logic [7:0] d);
    int off;
    bit sel, exp_set, run_clear;
    off = int'(a) - int'(BASE);
    sel = en && off >= 0 && off < 6;
    exp_set = 0;
    run_clear = 0;
    if (sel && !we && off == 4) m_shadow = m_count / 256;
    if (m_run) begin
      if (m_wait == 0) begin
        m_wait = m_pres;
        if (m_count > 0) m_count = m_count - 1;
        else begin
          exp_set = 1;
          if (m_per) m_count = m_reload;
          else run_clear = 1;
        end
      end else begin
        m_wait = m_wait - 1;
      end
    end
    if (sel && we) begin
      case (off)
        0: begin
          if (!m_run && d[0]) begin
            m_count = m_reload;
            m_wait  = m_pres;
          end
          m_run = d[0]; m_per = d[1]; m_irqen = d[2];
          if (!d[7]) m_exp = 0;
        end
        1: m_pres = int'(d);
        2: m_reload = (m_reload & 32'hFF00) | int'(d);
        3: m_reload = (m_reload & 32'h00FF) | (int'(d) << 8);
        default: ;
      endcase
    end
    if (exp_set) m_exp = 1;
    if (run_clear) m_run = 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive at negedge, sample 1ns later, model advances at posedge.
  task automatic step(input bit en, input logic [15:0] a, input bit we, input logic [7:0] d,
                      input bit chk);
    @(negedge clk);
    enable = en; addr = a; write_en = we; data_in = d;
    #1;
    cur_dout = int'(data_out);
    cur_irq  = int'(wake_irq);
    if (chk) begin
      check("model_dout", cur_dout, model_dout(en, a, we));
      check("model_irq", cur_irq, int'(m_exp && m_irqen));
    end
    @(posedge clk);
    model_step(en, a, we, d);
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    step(1'b1, BASE + 16'(off), 1'b1, d, 1'b1);
  endtask

  task automatic rd(input int off);
    step(1'b1, BASE + 16'(off), 1'b0, 8'h00, 1'b1);
  endtask

  typedef struct {
    bit          en;
    logic [15:0] a;
    bit          we;
    logic [7:0]  d;
    logic [7:0]  dout;
    bit          irq;
  } vec_t;

  vec_t tbl[$];

  int cnt_exp[12] = '{2, 2, 1, 1, 0, 0, 2, 2, 1, 1, 0, 0};
  int irq_exp[12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

  initial begin
    int guard;
    reset = 1'b0; enable = 1'b0; addr = 16'h0000; write_en = 1'b0; data_in = 8'h00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    enable = 1'b1; addr = BASE; #1;
    check("reset_dout", int'(data_out), 0);
    check("reset_irq", int'(wake_irq), 0);
    @(negedge clk);
    reset = 1'b1;

    // Register access and decode table, all from reset state.
    tbl.push_back('{1, BASE + 16'd0, 0, 8'h00, 8'h00, 0});
    tbl.push_back('{1, BASE + 16'd1, 0, 8'h00, 8'h00, 0});
    tbl.push_back('{1, BASE + 16'd1, 1, 8'h5A, 8'h00, 0});
    tbl.push_back('{1, BASE + 16'd1, 0, 8'h00, 8'h5A, 0});
    tbl.push_back('{1, BASE + 16'd2, 1, 8'h34, 8'h00, 0});
    tbl.push_back('{1, BASE + 16'd2, 0, 8'h00, 8'h34, 0});
    tbl.push_back('{1, BASE + 16'd3, 1, 8'h12, 8'h00, 0});
    tbl.push_back('{1, BASE + 16'd3, 0, 8'h00, 8'h12, 0});
    tbl.push_back('{1, BASE + 16'd4, 1, 8'hFF, 8'h00, 0});
    tbl.push_back('{1, BASE + 16'd4, 0, 8'h00, 8'h00, 0});
    tbl.push_back('{1, BASE + 16'd5, 1, 8'hEE, 8'h00, 0});
    tbl.push_back('{1, BASE + 16'd5, 0, 8'h00, 8'h00, 0});
    tbl.push_back('{1, BASE + 16'd6, 1, 8'h99, 8'h00, 0});
    tbl.push_back('{1, BASE + 16'd6, 0, 8'h00, 8'h00, 0});
    tbl.push_back('{1, BASE - 16'd1, 1, 8'h77, 8'h00, 0});
    tbl.push_back('{1, BASE - 16'd1, 0, 8'h00, 8'h00, 0});
    tbl.push_back('{0, BASE + 16'd1, 1, 8'h11, 8'h00, 0});
    tbl.push_back('{0, BASE + 16'd1, 0, 8'h00, 8'h00, 0});
    tbl.push_back('{1, BASE + 16'd1, 0, 8'h00, 8'h5A, 0});
    tbl.push_back('{1, BASE + 16'd0, 1, 8'h7E, 8'h00, 0});
    tbl.push_back('{1, BASE + 16'd0, 0, 8'h00, 8'h06, 0});
    tbl.push_back('{1, BASE + 16'd0, 1, 8'h00, 8'h00, 0});
    tbl.push_back('{1, BASE + 16'd0, 0, 8'h00, 8'h00, 0});
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].a, tbl[i].we, tbl[i].d, 1'b0);
      check($sformatf("tbl%0d_dout", i), cur_dout, int'(tbl[i].dout));
      check($sformatf("tbl%0d_irq", i), cur_irq, int'(tbl[i].irq));
    end

    // One-shot: irq exactly 4 clocks after the start write, run cleared.
    wr(1, 8'h00); wr(2, 8'h03); wr(3, 8'h00);
    wr(0, 8'h05);
    for (int i = 0; i < 4; i++) begin
      rd(4);
      check($sformatf("oneshot_irq_low%0d", i), cur_irq, 0);
    end
    rd(0);
    check("oneshot_ctrl", cur_dout, 8'h84);
    check("oneshot_irq", cur_irq, 1);
    wr(0, 8'h00);
    rd(0);
    check("oneshot_clear", cur_dout, 8'h00);

    // Periodic: PRESCALE=1, RELOAD=2 -> expiry every 6 clocks.
    wr(1, 8'h01); wr(2, 8'h02);
    wr(0, 8'h07);
    for (int i = 0; i < 12; i++) begin
      rd(4);
      check($sformatf("per_count%0d", i), cur_dout, cnt_exp[i]);
      check($sformatf("per_irq%0d", i), cur_irq, irq_exp[i]);
    end
    wr(0, 8'h07);
    check("per_irq_before_clear", cur_irq, 1);
    rd(0);
    check("per_ctrl_cleared", cur_dout, 8'h07);
    check("per_irq_cleared", cur_irq, 0);

    // Clear colliding with an expiry tick: flag must survive.
    guard = 0;
    while (!model_expiring() && guard < 100) begin
      rd(4);
      guard++;
    end
    check("collide_wait_bound", int'(guard < 100), 1);
    wr(0, 8'h07);
    rd(0);
    check("collide_ctrl", cur_dout, 8'h87);
    check("collide_irq", cur_irq, 1);
    wr(0, 8'h00);

    // Snapshot: COUNT_H returns the high byte captured by the COUNT_L read.
    wr(1, 8'h03); wr(2, 8'h00); wr(3, 8'h01);
    wr(0, 8'h01);
    rd(4);
    check("snap_count_l", cur_dout, 8'h00);
    rd(2); rd(2); rd(2);
    rd(5);
    check("snap_count_h", cur_dout, 8'h01);
    rd(4);
    check("snap_count_l_after", cur_dout, 8'hFF);
    rd(5);
    check("snap_count_h_after", cur_dout, 8'h00);

    // Reset mid-count: everything back to zero, no expiry afterwards.
    wr(0, 8'h00);
    wr(1, 8'h00); wr(2, 8'h05); wr(3, 8'h00);
    wr(0, 8'h07);
    rd(4); rd(4);
    check("prerst_count", cur_dout, 8'h04);
    @(negedge clk);
    reset = 1'b0; enable = 1'b1; addr = BASE; write_en = 1'b0;
    #1;
    check("midrst_dout", int'(data_out), 0);
    check("midrst_irq", int'(wake_irq), 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      rd(i);
      check($sformatf("postrst_reg%0d", i), cur_dout, 0);
    end
    for (int i = 0; i < 20; i++) begin
      rd(0);
      check($sformatf("postrst_idle%0d", i), cur_dout + cur_irq, 0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit          en, we;
      int          off;
      logic [15:0] a;
      logic [7:0]  d;
      en  = ($urandom_range(0, 7) != 0);
      off = $urandom_range(0, 7);
      a   = ($urandom_range(0, 15) == 0) ? 16'($urandom) : BASE + 16'(off);
      we  = ($urandom_range(0, 3) == 0);
      d   = 8'($urandom);
      if (off == 1) d = d & 8'h03;
      if (off == 2) d = d & 8'h07;
      if (off == 3 && $urandom_range(0, 3) != 0) d = 8'h00;
      step(en, a, we, d, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reflet_wakeup_timer.md
REFLET_WAKEUP_TIMER -- requirements
Module: reflet_wakeup_timer

Interface
REQ-001 SHALL have parameter base_addr_size, default 16, width of the system bus address.
REQ-002 SHALL have parameter base_addr, default 16'hFF20, address of the first of 6 byte registers.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port enable  input  1  bus access qualifier.
REQ-006 SHALL have port addr  input  base_addr_size  system bus address.
REQ-007 SHALL have port write_en  input  1  write strobe, sampled on clk when selected.
REQ-008 SHALL have port data_in  input  8  write data.
REQ-009 SHALL have port data_out  output  8  read data; 8'h00 when not selected or when write_en=1.
REQ-010 SHALL have port wake_irq  output  1  interrupt line, intended for one bit of the power manager's cpu_interrupts; must operate while the CPU is gated.

Function
REQ-011 SHALL be selected when enable=1 and base_addr <= addr < base_addr+6; offset = addr-base_addr.
REQ-012 SHALL map: 0 CTRL (bit0 run, bit1 periodic, bit2 irq_en, bit7 expired flag, bits6:3 read 0); 1 PRESCALE; 2 RELOAD_L; 3 RELOAD_H; 4 COUNT_L (RO); 5 COUNT_H (RO, shadow).
REQ-013 SHALL implement states IDLE (run=0) and COUNTING (run=1); state is CTRL.run.
REQ-014 SHALL, on a CTRL write with run 0->1, load count<=RELOAD and prescale counter<=0 in that cycle; counting starts next cycle.
REQ-015 SHALL, in COUNTING, produce one tick every PRESCALE+1 clk cycles (PRESCALE=0 -> every cycle).
REQ-016 SHALL, on a tick with count!=0, decrement count by 1.
REQ-017 SHALL, on a tick with count==0, set expired flag; if periodic=1 reload count<=RELOAD and stay COUNTING; else clear run and go IDLE.
REQ-018 SHALL treat RELOAD=0 as expiry on every tick (period = PRESCALE+1 clk).
REQ-019 SHALL drive wake_irq = expired & irq_en, registered-flag based, no combinational path from bus.
REQ-020 SHALL clear expired flag only by a CTRL write with bit7=0; writing bit7=1 leaves flag unchanged.
REQ-021 SHALL give flag set priority over a same-cycle clear.
REQ-022 SHALL, on CTRL write with run 1->0, stop immediately; count and flag hold.
REQ-023 SHALL, on CTRL write with run 1->1, not reload; periodic/irq_en update only.
REQ-024 SHALL apply RELOAD/PRESCALE writes during COUNTING to the next reload / next prescale wrap only.
REQ-025 SHALL, while COUNT_L is being read, latch count[15:8] into the COUNT_H shadow each cycle; COUNT_H read returns the shadow.
REQ-026 SHALL ignore writes to offsets 4 and 5.
REQ-027 SHALL drive data_out combinationally from offset and register state.

Reset
REQ-028 SHALL, while reset=0, asynchronously clear CTRL, PRESCALE, RELOAD, count, prescale counter and shadow to 0; wake_irq=0, data_out=0.
REQ-029 SHALL, on reset assertion mid-count, abort with no pending flag after release.

Verification
REQ-030 One-shot: PRESCALE=0, RELOAD=3, CTRL=8'h05 -> expired and wake_irq=1 exactly 4 clk after the write's edge; CTRL reads 8'h84 (run cleared).
REQ-031 Periodic: PRESCALE=1, RELOAD=2, CTRL=8'h07 -> expiry every 6 clk, count sequence 2,1,0,2,...; irq stays high until CTRL=8'h07 write clears bit7.
REQ-032 Set/clear collision: write CTRL bit7=0 in the same cycle as an expiry tick -> flag remains 1.
REQ-033 Snapshot: RELOAD=16'h0100, read COUNT_L when count=16'h0100 then COUNT_H after decrement -> reads 8'h00 then 8'h01.
REQ-034 Reset mid-operation: reset=0 for 1 cycle while COUNTING -> all registers read 0, wake_irq=0, no expiry thereafter.
REQ-035 Decode: addr=base_addr+6 write -> no state change; data_out=0 when enable=0 or unselected.
